// File: rtl/ttc_pkg.sv
// ttc_pkg: shared encodings and defaults for the TTC fast-control
// self-test generator and the receive-side checker.
package ttc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FIRE  = 2'd1,
      ST_GAP   = 2'd2,
      ST_GUARD = 2'd3
   } ttc_state_e;

   typedef enum logic [1:0] {
      MM_NONE = 2'b00,
      MM_ALL  = 2'b01,
      MM_ALT  = 2'b10,
      MM_LAST = 2'b11
   } match_mode_e;

   localparam int ORBIT_LEN_DEF    = 3564;
   localparam int MIN_SPACING_DEF  = 3;
   localparam int RESYNC_GUARD_DEF = 16;

   typedef struct packed {
      logic [11:0] bx;
      logic        bc0;
   } bx_st_t;

   typedef struct packed {
      ttc_state_e  st;
      match_mode_e mode;
      logic [7:0]  rem;
      logic [7:0]  sp;
      logic [7:0]  gap;
      logic [15:0] gcnt;
      logic        alt;
      logic        rs_pend;
      logic        l1a;
      logic        match;
      logic        resync;
      logic        busy;
      logic [23:0] cnt;
   } gen_st_t;

endpackage

// File: rtl/ttc_bx_counter.sv
// ttc_bx_counter: orbit BX counter with registered BC0 strobe and
// synchronous clear, optionally triplicated.
module ttc_bx_counter
   import ttc_pkg::*;
#(
   parameter int ORBIT_LEN = ORBIT_LEN_DEF,
   parameter int BC0_BX    = 0,
   parameter int TMR       = 0
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        en_i,
   input  logic        bc0_en_i,
   input  logic        clr_i,
   output logic [11:0] bx_o,
   output logic        bc0_o
);

   localparam logic [11:0] BX_LAST = 12'(ORBIT_LEN - 1);
   localparam logic [11:0] BX_BC0  = 12'(BC0_BX);
   localparam int          W       = $bits(bx_st_t);

   bx_st_t st_q;
   bx_st_t st_d;

   // BC0 is compared against the next BX so it lines up with BX_CNT
   always_comb begin
      st_d = st_q;
      if (clr_i) begin
         st_d.bx = 12'd0;
      end else if (en_i) begin
         st_d.bx = (st_q.bx == BX_LAST) ? 12'd0 : st_q.bx + 12'd1;
      end
      st_d.bc0 = en_i && bc0_en_i && (st_d.bx == BX_BC0);
   end

   if (TMR != 0) begin : g_tmr
      logic [W-1:0] c0_q;
      logic [W-1:0] c1_q;
      logic [W-1:0] c2_q;
      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            c0_q <= '0;
            c1_q <= '0;
            c2_q <= '0;
         end else begin
            c0_q <= st_d;
            c1_q <= st_d;
            c2_q <= st_d;
         end
      end
      assign st_q = (c0_q & c1_q) | (c0_q & c2_q) | (c1_q & c2_q);
   end else begin : g_one
      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) st_q <= '0;
         else       st_q <= st_d;
      end
   end

   assign bx_o  = st_q.bx;
   assign bc0_o = st_q.bc0;

endmodule

// File: rtl/ttc_cmd_gen.sv
// ttc_cmd_gen: self-test source of the L1A / L1A_MATCH / RESYNC / BC0
// fast-control stream at CLK40, with burst FSM and resync guard.
module ttc_cmd_gen
   import ttc_pkg::*;
#(
   parameter int ORBIT_LEN    = ORBIT_LEN_DEF,
   parameter int BC0_BX       = 0,
   parameter int MIN_SPACING  = MIN_SPACING_DEF,
   parameter int RESYNC_GUARD = RESYNC_GUARD_DEF,
   parameter int TMR          = 0
) (
   input  logic        CLK40,
   input  logic        RST,
   input  logic        ENABLE,
   input  logic        BC0_EN,
   input  logic        L1A_REQ,
   input  logic [7:0]  L1A_NUM,
   input  logic [7:0]  L1A_SPACING,
   input  logic [1:0]  MATCH_MODE,
   input  logic        RESYNC_REQ,
   output logic        L1A,
   output logic        L1A_MATCH,
   output logic        RESYNC,
   output logic        BC0,
   output logic [11:0] BX_CNT,
   output logic [23:0] L1A_CNT,
   output logic        BUSY
);

   localparam logic [7:0]  MIN_SP = 8'(MIN_SPACING);
   localparam logic [15:0] G_LAST = 16'(RESYNC_GUARD - 1);
   localparam int          W      = $bits(gen_st_t);

   gen_st_t st_q;
   gen_st_t st_d;
   logic    accept;

   // a RESYNC request in the same cycle outranks a burst request
   assign accept = L1A_REQ && ENABLE && (L1A_NUM != 8'd0) && !RESYNC_REQ;

   always_comb begin
      st_d         = st_q;
      st_d.l1a     = 1'b0;
      st_d.match   = 1'b0;
      st_d.resync  = 1'b0;
      st_d.busy    = (st_q.st != ST_IDLE);
      st_d.rs_pend = RESYNC_REQ;
      if (st_q.rs_pend) begin
         st_d.resync = 1'b1;
         st_d.cnt    = 24'd0;
         st_d.st     = ST_GUARD;
         st_d.gcnt   = G_LAST;
      end else begin
         unique case (st_q.st)
            ST_IDLE: begin
               if (accept) begin
                  st_d.st   = ST_FIRE;
                  st_d.rem  = L1A_NUM;
                  st_d.sp   = (L1A_SPACING < MIN_SP) ? MIN_SP : L1A_SPACING;
                  st_d.mode = match_mode_e'(MATCH_MODE);
                  st_d.alt  = 1'b0;
               end
            end
            ST_FIRE: begin
               if (!ENABLE) begin
                  st_d.st = ST_IDLE;
               end else begin
                  st_d.l1a = 1'b1;
                  st_d.cnt = st_q.cnt + 24'd1;
                  st_d.rem = st_q.rem - 8'd1;
                  st_d.alt = ~st_q.alt;
                  st_d.gap = st_q.sp - 8'd2;
                  st_d.st  = (st_q.rem == 8'd1) ? ST_IDLE : ST_GAP;
                  unique case (st_q.mode)
                     MM_NONE: st_d.match = 1'b0;
                     MM_ALL:  st_d.match = 1'b1;
                     MM_ALT:  st_d.match = ~st_q.alt;
                     MM_LAST: st_d.match = (st_q.rem == 8'd1);
                  endcase
               end
            end
            ST_GAP: begin
               if (!ENABLE)                st_d.st  = ST_IDLE;
               else if (st_q.gap == 8'd0)  st_d.st  = ST_FIRE;
               else                        st_d.gap = st_q.gap - 8'd1;
            end
            ST_GUARD: begin
               if (st_q.gcnt == 16'd0) st_d.st   = ST_IDLE;
               else                    st_d.gcnt = st_q.gcnt - 16'd1;
            end
         endcase
      end
   end

   if (TMR != 0) begin : g_tmr
      logic [W-1:0] c0_q;
      logic [W-1:0] c1_q;
      logic [W-1:0] c2_q;
      always_ff @(posedge CLK40 or posedge RST) begin
         if (RST) begin
            c0_q <= '0;
            c1_q <= '0;
            c2_q <= '0;
         end else begin
            c0_q <= st_d;
            c1_q <= st_d;
            c2_q <= st_d;
         end
      end
      assign st_q = (c0_q & c1_q) | (c0_q & c2_q) | (c1_q & c2_q);
   end else begin : g_one
      always_ff @(posedge CLK40 or posedge RST) begin
         if (RST) st_q <= '0;
         else     st_q <= st_d;
      end
   end

   ttc_bx_counter #(
      .ORBIT_LEN (ORBIT_LEN),
      .BC0_BX    (BC0_BX),
      .TMR       (TMR)
   ) u_bx (
      .clk_i    (CLK40),
      .rst_i    (RST),
      .en_i     (ENABLE),
      .bc0_en_i (BC0_EN),
      .clr_i    (st_q.rs_pend),
      .bx_o     (BX_CNT),
      .bc0_o    (BC0)
   );

   assign L1A       = st_q.l1a;
   assign L1A_MATCH = st_q.match;
   assign RESYNC    = st_q.resync;
   assign L1A_CNT   = st_q.cnt;
   assign BUSY      = st_q.busy;

endmodule

// File: tb/tb_ttc_cmd_gen.sv
// tb_ttc_cmd_gen: directed checks of the TTC command generator, with a
// TMR=1 twin driven in lockstep.
module tb_ttc_cmd_gen;

   logic       CLK40 = 1'b0;
   logic       RST = 1'b1;
   logic       ENABLE = 1'b0;
   logic       BC0_EN = 1'b0;
   logic       L1A_REQ = 1'b0;
   logic       RESYNC_REQ = 1'b0;
   logic [7:0] L1A_NUM = 8'd0;
   logic [7:0] L1A_SPACING = 8'd0;
   logic [1:0] MATCH_MODE = 2'd0;

   logic        L1A, L1A_MATCH, RESYNC, BC0, BUSY;
   logic [11:0] BX_CNT;
   logic [23:0] L1A_CNT;
   logic        t_l1a, t_match, t_rs, t_bc0, t_busy;
   logic [11:0] t_bx;
   logic [23:0] t_cnt;

   int total = 0;
   int bad = 0;

   logic [63:0] v_l1a, v_match, v_rs, v_busy, tv_l1a, tv_rs;
   logic [11:0] bx_at [64];
   logic [23:0] cnt_at [64];

   always #5 CLK40 = ~CLK40;

   ttc_cmd_gen #(.TMR(0)) dut (
      .CLK40(CLK40), .RST(RST), .ENABLE(ENABLE), .BC0_EN(BC0_EN),
      .L1A_REQ(L1A_REQ), .L1A_NUM(L1A_NUM), .L1A_SPACING(L1A_SPACING),
      .MATCH_MODE(MATCH_MODE), .RESYNC_REQ(RESYNC_REQ),
      .L1A(L1A), .L1A_MATCH(L1A_MATCH), .RESYNC(RESYNC), .BC0(BC0),
      .BX_CNT(BX_CNT), .L1A_CNT(L1A_CNT), .BUSY(BUSY)
   );

   ttc_cmd_gen #(.TMR(1)) u_tmr (
      .CLK40(CLK40), .RST(RST), .ENABLE(ENABLE), .BC0_EN(BC0_EN),
      .L1A_REQ(L1A_REQ), .L1A_NUM(L1A_NUM), .L1A_SPACING(L1A_SPACING),
      .MATCH_MODE(MATCH_MODE), .RESYNC_REQ(RESYNC_REQ),
      .L1A(t_l1a), .L1A_MATCH(t_match), .RESYNC(t_rs), .BC0(t_bc0),
      .BX_CNT(t_bx), .L1A_CNT(t_cnt), .BUSY(t_busy)
   );

   task automatic tick();
      @(posedge CLK40);
      #1;
   endtask

   task automatic clear_obs();
      v_l1a = '0; v_match = '0; v_rs = '0; v_busy = '0;
      tv_l1a = '0; tv_rs = '0;
   endtask

   task automatic record(input int t);
      v_l1a[t] = L1A;
      v_match[t] = L1A_MATCH;
      v_rs[t] = RESYNC;
      v_busy[t] = BUSY;
      tv_l1a[t] = t_l1a;
      tv_rs[t] = t_rs;
      bx_at[t] = BX_CNT;
      cnt_at[t] = L1A_CNT;
   endtask

   task automatic start_burst(input logic [7:0] n, input logic [7:0] sp,
                              input logic [1:0] mm);
      L1A_NUM = n;
      L1A_SPACING = sp;
      MATCH_MODE = mm;
      L1A_REQ = 1'b1;
      clear_obs();
   endtask

   task automatic test_reset();
      RST = 1'b1;
      tick();
      tick();
      total++;
      if ({L1A, L1A_MATCH, RESYNC, BC0, BUSY} !== 5'b0) begin
         bad++;
         $display("FAIL reset_strobes got=%b want=00000",
                  {L1A, L1A_MATCH, RESYNC, BC0, BUSY});
      end
      total++;
      if (BX_CNT !== 12'd0) begin
         bad++; $display("FAIL reset_bx got=%0d want=0", BX_CNT);
      end
      total++;
      if (L1A_CNT !== 24'd0) begin
         bad++; $display("FAIL reset_cnt got=%0d want=0", L1A_CNT);
      end
      #3;
      RST = 1'b0;
   endtask

   task automatic test_bc0();
      int bx_exp = 0;
      int err = 0;
      int first = -1;
      int n_bc0 = 0;
      int last = -1;
      int gap = 0;
      int busy_err = 0;
      logic exp_bc0;
      BC0_EN = 1'b1;
      for (int i = 0; i < 7200; i++) begin
         ENABLE = !(i >= 50 && i < 55);
         tick();
         if (ENABLE) bx_exp = (bx_exp == 3563) ? 0 : bx_exp + 1;
         exp_bc0 = ENABLE && (bx_exp == 0);
         if (BX_CNT !== 12'(bx_exp) || BC0 !== exp_bc0) begin
            if (first < 0) first = i;
            err++;
         end
         if (BC0 === 1'b1) begin
            if (last >= 0) gap = i - last;
            last = i;
            n_bc0++;
         end
         if (BUSY !== 1'b0) busy_err++;
      end
      ENABLE = 1'b1;
      total++;
      if (err != 0) begin
         bad++;
         $display("FAIL bx_bc0_track got=%0d errors (first at %0d) want=0",
                  err, first);
      end
      total++;
      if (n_bc0 != 2) begin
         bad++; $display("FAIL bc0_count got=%0d want=2", n_bc0);
      end
      total++;
      if (gap != 3564) begin
         bad++; $display("FAIL bc0_period got=%0d want=3564", gap);
      end
      total++;
      if (busy_err != 0) begin
         bad++; $display("FAIL bc0_busy got=%0d high cycles want=0", busy_err);
      end
   endtask

   task automatic test_burst();
      start_burst(8'd4, 8'd10, 2'b10);
      for (int t = 1; t < 64; t++) begin
         tick();
         L1A_REQ = 1'b0;
         record(t);
      end
      total++;
      if (v_l1a !== 64'h0000_0001_0040_1004) begin
         bad++; $display("FAIL burst_l1a got=%h want=%h", v_l1a,
                         64'h0000_0001_0040_1004);
      end
      total++;
      if (v_match !== 64'h0000_0000_0040_0004) begin
         bad++; $display("FAIL burst_match got=%h want=%h", v_match,
                         64'h0000_0000_0040_0004);
      end
      total++;
      if (v_busy !== 64'h0000_0001_FFFF_FFFC) begin
         bad++; $display("FAIL burst_busy got=%h want=%h", v_busy,
                         64'h0000_0001_FFFF_FFFC);
      end
      total++;
      if (cnt_at[63] !== 24'd4) begin
         bad++; $display("FAIL burst_cnt got=%0d want=4", cnt_at[63]);
      end
   endtask

   task automatic test_clamp();
      start_burst(8'd3, 8'd1, 2'b11);
      for (int t = 1; t < 64; t++) begin
         tick();
         L1A_REQ = 1'b0;
         record(t);
      end
      total++;
      if (v_l1a !== 64'h124) begin
         bad++; $display("FAIL clamp_l1a got=%h want=%h", v_l1a, 64'h124);
      end
      total++;
      if (v_match !== 64'h100) begin
         bad++; $display("FAIL clamp_match got=%h want=%h", v_match, 64'h100);
      end
      total++;
      if (cnt_at[63] !== 24'd7) begin
         bad++; $display("FAIL clamp_cnt got=%0d want=7", cnt_at[63]);
      end
   endtask

   task automatic test_resync_collide();
      start_burst(8'd1, 8'd5, 2'b01);
      RESYNC_REQ = 1'b1;
      for (int t = 1; t < 64; t++) begin
         tick();
         RESYNC_REQ = 1'b0;
         record(t);
         L1A_REQ = (t == 11 || t == 18);
      end
      total++;
      if (v_rs !== 64'h4) begin
         bad++; $display("FAIL rsc_resync got=%h want=%h", v_rs, 64'h4);
      end
      total++;
      if (v_l1a !== 64'h10_0000) begin
         bad++; $display("FAIL rsc_l1a got=%h want=%h", v_l1a, 64'h10_0000);
      end
      total++;
      if (v_match !== 64'h10_0000) begin
         bad++; $display("FAIL rsc_match got=%h want=%h", v_match, 64'h10_0000);
      end
      total++;
      if (bx_at[2] !== 12'd0 || bx_at[20] !== 12'd18) begin
         bad++; $display("FAIL rsc_bx got=%0d,%0d want=0,18",
                         bx_at[2], bx_at[20]);
      end
      total++;
      if (cnt_at[1] !== 24'd7 || cnt_at[2] !== 24'd0 ||
          cnt_at[63] !== 24'd1) begin
         bad++; $display("FAIL rsc_cnt got=%0d,%0d,%0d want=7,0,1",
                         cnt_at[1], cnt_at[2], cnt_at[63]);
      end
   endtask

   task automatic test_resync_mid();
      start_burst(8'd5, 8'd4, 2'b01);
      for (int t = 1; t < 64; t++) begin
         tick();
         L1A_REQ = 1'b0;
         record(t);
         RESYNC_REQ = (t == 7);
      end
      total++;
      if (v_l1a !== 64'h44 || v_match !== 64'h44) begin
         bad++; $display("FAIL rsm_l1a got=%h/%h want=%h", v_l1a, v_match,
                         64'h44);
      end
      total++;
      if (v_rs !== 64'h200) begin
         bad++; $display("FAIL rsm_resync got=%h want=%h", v_rs, 64'h200);
      end
      total++;
      if (bx_at[9] !== 12'd0) begin
         bad++; $display("FAIL rsm_bx got=%0d want=0", bx_at[9]);
      end
      total++;
      if (cnt_at[6] !== 24'd3 || cnt_at[9] !== 24'd0 ||
          cnt_at[63] !== 24'd0) begin
         bad++; $display("FAIL rsm_cnt got=%0d,%0d,%0d want=3,0,0",
                         cnt_at[6], cnt_at[9], cnt_at[63]);
      end
      total++;
      if (v_busy[63:24] !== 40'h3) begin
         bad++; $display("FAIL rsm_busy got=%h want=%h", v_busy[63:24], 40'h3);
      end
   endtask

   task automatic test_rst_mid_gap();
      start_burst(8'd4, 8'd10, 2'b01);
      for (int t = 1; t <= 5; t++) begin
         tick();
         L1A_REQ = 1'b0;
      end
      #3;
      RST = 1'b1;
      #1;
      total++;
      if ({L1A, L1A_MATCH, RESYNC, BC0, BUSY} !== 5'b0 ||
          L1A_CNT !== 24'd0 || BX_CNT !== 12'd0) begin
         bad++;
         $display("FAIL rst_async got=%b cnt=%0d bx=%0d want=00000 0 0",
                  {L1A, L1A_MATCH, RESYNC, BC0, BUSY}, L1A_CNT, BX_CNT);
      end
      #2;
      RST = 1'b0;
      start_burst(8'd2, 8'd3, 2'b01);
      for (int t = 1; t < 64; t++) begin
         tick();
         L1A_REQ = 1'b0;
         record(t);
      end
      total++;
      if (v_l1a !== 64'h24 || v_match !== 64'h24) begin
         bad++; $display("FAIL rst_new_burst got=%h/%h want=%h", v_l1a,
                         v_match, 64'h24);
      end
      total++;
      if (cnt_at[10] !== 24'd2 || bx_at[5] !== 12'd5) begin
         bad++; $display("FAIL rst_counts got=%0d,%0d want=2,5",
                         cnt_at[10], bx_at[5]);
      end
   endtask

   task automatic test_enable_drop();
      start_burst(8'd4, 8'd5, 2'b00);
      for (int t = 1; t < 64; t++) begin
         tick();
         L1A_REQ = 1'b0;
         record(t);
         if (t == 3) ENABLE = 1'b0;
         if (t == 9) ENABLE = 1'b1;
      end
      total++;
      if (v_l1a !== 64'h4 || v_match !== 64'h0) begin
         bad++; $display("FAIL en_l1a got=%h/%h want=%h/%h", v_l1a, v_match,
                         64'h4, 64'h0);
      end
      total++;
      if (v_busy !== 64'h1C) begin
         bad++; $display("FAIL en_busy got=%h want=%h", v_busy, 64'h1C);
      end
   endtask

   task automatic test_tmr();
      int diff = 0;
      start_burst(8'd3, 8'd4, 2'b10);
      for (int t = 1; t < 64; t++) begin
         tick();
         L1A_REQ = 1'b0;
         if (t == 6) release u_tmr.g_tmr.c0_q;
         if (t == 31) release u_tmr.u_bx.g_tmr.c1_q;
         if ({L1A, L1A_MATCH, RESYNC, BC0, BUSY, BX_CNT, L1A_CNT} !==
             {t_l1a, t_match, t_rs, t_bc0, t_busy, t_bx, t_cnt}) diff++;
         record(t);
         RESYNC_REQ = (t == 20);
         if (t == 5) force u_tmr.g_tmr.c0_q = '1;
         if (t == 30) force u_tmr.u_bx.g_tmr.c1_q = '1;
      end
      total++;
      if (diff != 0) begin
         bad++; $display("FAIL tmr_lockstep got=%0d differing cycles want=0",
                         diff);
      end
      total++;
      if (tv_l1a !== 64'h444) begin
         bad++; $display("FAIL tmr_l1a got=%h want=%h", tv_l1a, 64'h444);
      end
      total++;
      if (tv_rs !== 64'h40_0000) begin
         bad++; $display("FAIL tmr_resync got=%h want=%h", tv_rs, 64'h40_0000);
      end
   endtask

   initial begin
      test_reset();
      test_bc0();
      test_burst();
      test_clamp();
      test_resync_collide();
      test_resync_mid();
      test_rst_mid_gap();
      test_enable_drop();
      test_tmr();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
